// File: rtl/hc595_pkg.sv
// Shared types and helpers for the 74x595 chain driver.
package hc595_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_LATCH_HI,
    ST_LATCH_LO
  } state_t;

  typedef struct packed {
    logic ser;
    logic srclk;
    logic rclk;
    logic srclr_bar;
  } chain_pins_t;

  localparam logic SER_RST       = 1'b0;
  localparam logic SRCLK_RST     = 1'b0;
  localparam logic RCLK_RST      = 1'b0;
  localparam logic SRCLR_BAR_RST = 1'b1;
  localparam logic OE_BAR_RST    = 1'b1;

  localparam chain_pins_t PINS_RST = '{
    ser:       SER_RST,
    srclk:     SRCLK_RST,
    rclk:      RCLK_RST,
    srclr_bar: SRCLR_BAR_RST
  };

  function automatic int unsigned frame_w(input int unsigned n_chips);
    return 8 * n_chips;
  endfunction

  function automatic int unsigned bitcnt_w(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/hc595_chain_driver_if.sv
// Host frame handshake plus 595 chain pins; readback signals exist only with QH_READBACK_EN.
interface hc595_chain_driver_if #(
  parameter int unsigned N_CHIPS = 2
);
  localparam int unsigned W = hc595_pkg::frame_w(N_CHIPS);

  logic [W-1:0] DIN;
  logic         DIN_VALID;
  logic         DIN_READY;
  logic         CLR_REQ;
  logic         OE_EN;
  logic         BUSY;
  logic         SER;
  logic         SRCLK;
  logic         RCLK;
  logic         SRCLR_bar;
  logic         OE_bar;
`ifdef QH_READBACK_EN
  logic         QH_IN;
  logic [W-1:0] DOUT;
  logic         DOUT_VALID;

  modport master (
    output DIN, DIN_VALID, CLR_REQ, OE_EN, QH_IN,
    input  DIN_READY, BUSY, SER, SRCLK, RCLK, SRCLR_bar, OE_bar, DOUT, DOUT_VALID
  );
  modport slave (
    input  DIN, DIN_VALID, CLR_REQ, OE_EN, QH_IN,
    output DIN_READY, BUSY, SER, SRCLK, RCLK, SRCLR_bar, OE_bar, DOUT, DOUT_VALID
  );
`else
  modport master (
    output DIN, DIN_VALID, CLR_REQ, OE_EN,
    input  DIN_READY, BUSY, SER, SRCLK, RCLK, SRCLR_bar, OE_bar
  );
  modport slave (
    input  DIN, DIN_VALID, CLR_REQ, OE_EN,
    output DIN_READY, BUSY, SER, SRCLK, RCLK, SRCLR_bar, OE_bar
  );
`endif

endinterface

// File: rtl/hc595_phase_timer.sv
// Divides the system clock into serial phases: tick_c marks the last cycle of each phase.
module hc595_phase_timer #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick_c
);
  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick_c = (cnt == CW'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || tick_c) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/hc595_chain_driver.sv
// Serialises one 8*N_CHIPS-bit frame into a 74x595 daisy chain and latches it.
// Optional Qh' readback of the previous chain content when QH_READBACK_EN is defined.
module hc595_chain_driver
  import hc595_pkg::*;
#(
  parameter int unsigned N_CHIPS = 2,
  parameter int unsigned CLK_DIV = 4
) (
  input logic                 CLK,
  input logic                 RST_bar,
  hc595_chain_driver_if.slave bus
);
  localparam int unsigned W   = frame_w(N_CHIPS);
  localparam int unsigned BCW = bitcnt_w(W);

  state_t      state, state_n;
  logic [W-1:0]   shadow, shadow_n;
  logic [BCW-1:0] bitcnt, bitcnt_n;
  chain_pins_t pins, pins_n;
  logic        ready_q, ready_n;
  logic        busy_q;
  logic        oe_bar_q;
  logic        tick_c;
  logic        state_chg_c;

  assign state_chg_c = (state_n != state);

  hc595_phase_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_timer (
    .clk    (CLK),
    .rst_n  (RST_bar),
    .clr    (state_chg_c),
    .tick_c (tick_c)
  );

  // Next-state, next shadow/counter and next pin values; pins follow the state being entered.
  always_comb begin
    state_n  = state;
    shadow_n = shadow;
    bitcnt_n = bitcnt;
    pins_n   = PINS_RST;
    ready_n  = 1'b0;

    case (state)
      ST_IDLE: begin
        if (bus.CLR_REQ) begin
          state_n = ST_CLEAR;
        end else if (bus.DIN_VALID && ready_q) begin
          shadow_n = bus.DIN;
          bitcnt_n = BCW'(W);
          state_n  = ST_SHIFT_LO;
        end
      end
      ST_CLEAR:    if (tick_c) state_n = ST_LATCH_HI;
      ST_SHIFT_LO: if (tick_c) state_n = ST_SHIFT_HI;
      ST_SHIFT_HI: begin
        if (tick_c) begin
          shadow_n = {shadow[W-2:0], 1'b0};
          bitcnt_n = bitcnt - 1'b1;
          state_n  = (bitcnt == BCW'(1)) ? ST_LATCH_HI : ST_SHIFT_LO;
        end
      end
      ST_LATCH_HI: if (tick_c) state_n = ST_LATCH_LO;
      ST_LATCH_LO: if (tick_c) state_n = ST_IDLE;
      default:     state_n = ST_IDLE;
    endcase

    case (state_n)
      ST_CLEAR:    pins_n.srclr_bar = 1'b0;
      ST_SHIFT_LO: pins_n.ser = shadow_n[W-1];
      ST_SHIFT_HI: begin
        pins_n.ser   = shadow_n[W-1];
        pins_n.srclk = 1'b1;
      end
      ST_LATCH_HI: pins_n.rclk = 1'b1;
      default:     pins_n = PINS_RST;
    endcase

    ready_n = (state_n == ST_IDLE) && !bus.CLR_REQ;
  end

  always_ff @(posedge CLK) begin
    if (!RST_bar) begin
      state    <= ST_IDLE;
      shadow   <= '0;
      bitcnt   <= '0;
      pins     <= PINS_RST;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      oe_bar_q <= OE_BAR_RST;
    end else begin
      state    <= state_n;
      shadow   <= shadow_n;
      bitcnt   <= bitcnt_n;
      pins     <= pins_n;
      ready_q  <= ready_n;
      busy_q   <= (state_n != ST_IDLE);
      oe_bar_q <= ~bus.OE_EN;
    end
  end

  assign bus.SER       = pins.ser;
  assign bus.SRCLK     = pins.srclk;
  assign bus.RCLK      = pins.rclk;
  assign bus.SRCLR_bar = pins.srclr_bar;
  assign bus.DIN_READY = ready_q;
  assign bus.BUSY      = busy_q;
  assign bus.OE_bar    = oe_bar_q;

`ifdef QH_READBACK_EN
  logic [W-1:0] rb_sh;
  logic [W-1:0] dout_q;
  logic         dout_valid_q;
  logic         data_frame;

  // Qh' is sampled just before each SRCLK rise, so the frame collects the old chain MSB-first.
  always_ff @(posedge CLK) begin
    if (!RST_bar) begin
      rb_sh        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      data_frame   <= 1'b0;
    end else begin
      dout_valid_q <= 1'b0;
      if (state == ST_IDLE && state_n == ST_SHIFT_LO) data_frame <= 1'b1;
      if (state == ST_IDLE && state_n == ST_CLEAR)    data_frame <= 1'b0;
      if (state == ST_SHIFT_LO && tick_c) rb_sh <= {rb_sh[W-2:0], bus.QH_IN};
      if (state == ST_LATCH_LO && tick_c && data_frame) begin
        dout_q       <= rb_sh;
        dout_valid_q <= 1'b1;
      end
    end
  end

  assign bus.DOUT       = dout_q;
  assign bus.DOUT_VALID = dout_valid_q;
`endif

endmodule

// File: tb/tb_hc595_chain_driver.sv
// Directed bench for hc595_chain_driver (N_CHIPS=2, CLK_DIV=2) with a behavioural 595 chain.
module tb_hc595_chain_driver;

  logic CLK;
  logic RST_bar;
  int   n_assert = 0;
  int   n_fail   = 0;

  hc595_chain_driver_if #(.N_CHIPS(2)) hif ();

  hc595_chain_driver #(
    .N_CHIPS (2),
    .CLK_DIV (2)
  ) dut (
    .CLK     (CLK),
    .RST_bar (RST_bar),
    .bus     (hif)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Behavioural chain: shift register with async clear, storage latch on RCLK.
  logic [15:0] sr      = 16'h0000;
  logic [15:0] q       = 16'h0000;
  logic [15:0] ser_seq = 16'h0000;
  int          n_srclk = 0;
  int          n_rclk  = 0;

  always @(posedge hif.SRCLK or negedge hif.SRCLR_bar) begin
    if (!hif.SRCLR_bar) sr <= 16'h0000;
    else                sr <= {sr[14:0], hif.SER};
  end

  always @(posedge hif.SRCLK) begin
    ser_seq <= {ser_seq[14:0], hif.SER};
    n_srclk <= n_srclk + 1;
  end

  always @(posedge hif.RCLK) begin
    q      <= sr;
    n_rclk <= n_rclk + 1;
  end

`ifdef QH_READBACK_EN
  assign hif.QH_IN = sr[15];
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (hif.DIN_READY !== 1'b1 && n < 300) begin
      step();
      n++;
    end
    check("ready_wait", 32'(hif.DIN_READY), 32'd1);
  endtask

  task automatic wait_idle(output int busy);
    busy = 0;
    while (hif.BUSY === 1'b1 && busy < 300) begin
      busy++;
      step();
    end
  endtask

  task automatic send_frame(input logic [15:0] d, output int busy);
    wait_ready();
    hif.DIN       = d;
    hif.DIN_VALID = 1'b1;
    step();
    hif.DIN_VALID = 1'b0;
    wait_idle(busy);
  endtask

  initial begin
    int busy;
    int low;
    int base;
    int rdy_low;

    RST_bar       = 1'b0;
    hif.DIN       = '0;
    hif.DIN_VALID = 1'b0;
    hif.CLR_REQ   = 1'b0;
    hif.OE_EN     = 1'b0;
    repeat (3) step();

    // Reset values {SER,SRCLK,RCLK,SRCLR_bar,OE_bar,BUSY,DIN_READY}
    check("reset_pins", 32'({hif.SER, hif.SRCLK, hif.RCLK, hif.SRCLR_bar, hif.OE_bar,
                             hif.BUSY, hif.DIN_READY}), 32'b0001100);
    RST_bar = 1'b1;
    step();
    check("ready_after_reset", 32'(hif.DIN_READY), 32'd1);

    // Frame A55A: serial order, pulse counts, latched value, busy length
    base = n_srclk;
    hif.DIN       = 16'hA55A;
    hif.DIN_VALID = 1'b1;
    step();
    hif.DIN_VALID = 1'b0;
    check("a55a_ready_drop", 32'(hif.DIN_READY), 32'd0);
    check("a55a_first_ser", 32'(hif.SER), 32'd1);
    wait_idle(busy);
    check("a55a_busy_cycles", 32'(busy), 32'd68);
    check("a55a_ser_seq", 32'(ser_seq), 32'h0000A55A);
    check("a55a_srclk_rises", 32'(n_srclk - base), 32'd16);
    check("a55a_rclk_rises", 32'(n_rclk), 32'd1);
    check("a55a_q", 32'(q), 32'h0000A55A);
    check("a55a_ready_back", 32'(hif.DIN_READY), 32'd1);

    // Reset after five shifted bits of FFFF: frame dropped, latch untouched
    base = n_srclk;
    hif.DIN       = 16'hFFFF;
    hif.DIN_VALID = 1'b1;
    step();
    hif.DIN_VALID = 1'b0;
    low = 0;
    while ((n_srclk - base) < 5 && low < 100) begin
      step();
      low++;
    end
    check("mid_reset_5bits", 32'(n_srclk - base), 32'd5);
    RST_bar = 1'b0;
    step();
    check("mid_reset_pins", 32'({hif.SER, hif.SRCLK, hif.RCLK, hif.SRCLR_bar, hif.OE_bar,
                                 hif.BUSY, hif.DIN_READY}), 32'b0001100);
    check("mid_reset_q", 32'(q), 32'h0000A55A);
    check("mid_reset_rclk", 32'(n_rclk), 32'd1);
    RST_bar = 1'b1;

    // CLR_REQ and DIN_VALID together: clear wins, frame follows
    wait_ready();
    hif.CLR_REQ   = 1'b1;
    hif.DIN       = 16'hC3C3;
    hif.DIN_VALID = 1'b1;
    step();
    hif.CLR_REQ = 1'b0;
    check("clr_srclr_low", 32'(hif.SRCLR_bar), 32'd0);
    check("clr_ready_low", 32'(hif.DIN_READY), 32'd0);
    busy = 0;
    low  = 0;
    while (hif.BUSY === 1'b1 && busy < 300) begin
      busy++;
      if (hif.SRCLR_bar === 1'b0) low++;
      step();
    end
    check("clr_busy_cycles", 32'(busy), 32'd6);
    check("clr_srclr_cycles", 32'(low), 32'd2);
    check("clr_q_zero", 32'(q), 32'h00000000);
`ifdef QH_READBACK_EN
    check("clr_no_dout_valid", 32'(hif.DOUT_VALID), 32'd0);
`endif
    check("clr_ready_back", 32'(hif.DIN_READY), 32'd1);
    step();
    hif.DIN_VALID = 1'b0;
    check("clr_then_frame_busy", 32'(hif.BUSY), 32'd1);
    wait_idle(busy);
    check("clr_then_frame_q", 32'(q), 32'h0000C3C3);

    // Back-to-back 0001 then 8000 with DIN_VALID toggling while busy
    base = n_srclk;
    wait_ready();
    hif.DIN       = 16'h0001;
    hif.DIN_VALID = 1'b1;
    step();
    rdy_low = 0;
    while (hif.DIN_READY !== 1'b1 && rdy_low < 300) begin
      rdy_low++;
      if (rdy_low < 60) begin
        hif.DIN       = 16'hFFFF;
        hif.DIN_VALID = rdy_low[0];
      end else begin
        hif.DIN       = 16'h8000;
        hif.DIN_VALID = 1'b1;
      end
      step();
    end
    check("b2b_ready_gap", 32'(rdy_low), 32'd68);
    check("b2b_q_first", 32'(q), 32'h00000001);
    step();
    hif.DIN_VALID = 1'b0;
    check("b2b_second_busy", 32'(hif.BUSY), 32'd1);
    check("b2b_second_ready", 32'(hif.DIN_READY), 32'd0);
    wait_idle(busy);
    check("b2b_busy_cycles", 32'(busy), 32'd68);
    check("b2b_q_second", 32'(q), 32'h00008000);
    check("b2b_srclk_rises", 32'(n_srclk - base), 32'd32);

    // OE_bar follows ~OE_EN one cycle later, idle or busy
    hif.OE_EN = 1'b1;
    check("oe_idle_before", 32'(hif.OE_bar), 32'd1);
    step();
    check("oe_idle_after", 32'(hif.OE_bar), 32'd0);
    wait_ready();
    hif.DIN       = 16'h5A5A;
    hif.DIN_VALID = 1'b1;
    step();
    hif.DIN_VALID = 1'b0;
    repeat (3) step();
    hif.OE_EN = 1'b0;
    step();
    check("oe_busy_off", 32'({hif.OE_bar, hif.BUSY}), 32'b11);
    hif.OE_EN = 1'b1;
    step();
    check("oe_busy_on", 32'({hif.OE_bar, hif.BUSY}), 32'b01);
    wait_idle(busy);
    check("oe_frame_q", 32'(q), 32'h00005A5A);

`ifdef QH_READBACK_EN
    // Readback: second frame returns the chain content left by the first
    send_frame(16'h1234, busy);
    check("rb_first_valid", 32'(hif.DOUT_VALID), 32'd1);
    check("rb_first_dout", 32'(hif.DOUT), 32'h00005A5A);
    send_frame(16'hBEEF, busy);
    check("rb_second_valid", 32'(hif.DOUT_VALID), 32'd1);
    check("rb_second_dout", 32'(hif.DOUT), 32'h00001234);
    step();
    check("rb_valid_pulse", 32'(hif.DOUT_VALID), 32'd0);
    check("rb_q", 32'(q), 32'h0000BEEF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
